// File: rtl/cv32e40p_snn_pkg.sv
// Shared types and sizing for the cv32e40p SNN extension membrane cache.
// The LIF datapath honours the SNN_LIF_SATURATE_EN build macro (see cv32e40p_snn_lif_neuron).
package cv32e40p_snn_pkg;

    localparam int unsigned SNN_MEM_ROWS = 8;
    localparam int unsigned SNN_MEM_COLS = 16;
    localparam int unsigned SNN_MEM_DW   = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } lif_state_e;

    typedef logic signed [SNN_MEM_DW-1:0] snn_neuron_t;

endpackage

// File: rtl/cv32e40p_snn_lif_neuron.sv
// Combinational LIF update for one neuron: leak, integrate, threshold, reset.
// SNN_LIF_SATURATE_EN selects clamping instead of two's-complement wrap on narrowing.
module cv32e40p_snn_lif_neuron #(
    parameter int unsigned DW = 16
) (
    input  logic signed [DW-1:0] v_i,
    input  logic signed [DW-1:0] cur_i,
    input  logic signed [DW-1:0] thr_i,
    input  logic                 leak_en_i,
    input  logic [1:0]           leak_shift_i,
    input  logic                 reset_mode_i,
    output logic signed [DW-1:0] v_o,
    output logic                 spike_o
);

    logic signed [DW-1:0] leaked;
    logic signed [DW-1:0] sum;
    logic        [DW:0]   sum_w;
    logic        [DW:0]   sub_w;

    // Bring a DW+1 bit result back to DW bits.
    function automatic logic signed [DW-1:0] narrow(input logic [DW:0] x);
`ifdef SNN_LIF_SATURATE_EN
        if (x[DW] != x[DW-1]) begin
            return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
        return x[DW-1:0];
    endfunction

    always_comb begin
        leaked  = leak_en_i ? (v_i >>> leak_shift_i) : v_i;
        sum_w   = {leaked[DW-1], leaked} + {cur_i[DW-1], cur_i};
        sum     = narrow(sum_w);
        spike_o = (sum >= thr_i);
        sub_w   = {sum[DW-1], sum} - {thr_i[DW-1], thr_i};
        if (!spike_o) begin
            v_o = sum;
        end else if (reset_mode_i) begin
            v_o = narrow(sub_w);
        end else begin
            v_o = '0;
        end
    end

endmodule

// File: rtl/cv32e40p_snn_lif_ctrl.sv
// Row-serial LIF sequencer: two cycles per row (read, then compute + write back).
// Datapath narrowing follows SNN_LIF_SATURATE_EN in cv32e40p_snn_lif_neuron.
module cv32e40p_snn_lif_ctrl
    import cv32e40p_snn_pkg::*;
#(
    parameter int unsigned ROWS = SNN_MEM_ROWS,
    parameter int unsigned COLS = SNN_MEM_COLS,
    parameter int unsigned DW   = SNN_MEM_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     leak_en_i,
    input  logic [1:0]               leak_shift_i,
    input  logic [DW-1:0]            threshold_i,
    input  logic                     reset_mode_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     mem_rd_en_o,
    output logic [$clog2(ROWS)-1:0]  mem_addr_o,
    input  logic [COLS*DW-1:0]       mem_rdata_i,
    input  logic [COLS*DW-1:0]       cur_rdata_i,
    output logic                     mem_we_o,
    output logic [COLS*DW-1:0]       mem_wdata_o,
    output logic                     spike_we_o,
    output logic [COLS-1:0]          spike_o
);

    localparam int unsigned AW = $clog2(ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    lif_state_e           state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_en_q;
    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic                 leak_en_q;
    logic [1:0]           shift_q;
    logic signed [DW-1:0] thr_q;
    logic                 mode_q;

    logic [COLS*DW-1:0]   new_v;
    logic [COLS-1:0]      spike_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            leak_en_q <= 1'b0;
            shift_q   <= '0;
            thr_q     <= '0;
            mode_q    <= 1'b0;
        end else if (abort_i && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q   <= READ;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        addr_q    <= '0;
                        leak_en_q <= leak_en_i;
                        shift_q   <= leak_shift_i;
                        thr_q     <= threshold_i;
                        mode_q    <= reset_mode_i;
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    rd_en_q <= 1'b0;
                    we_q    <= 1'b1;
                end
                WRITE: begin
                    we_q <= 1'b0;
                    if (addr_q == LAST_ROW) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                        addr_q  <= addr_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    addr_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_neuron
        cv32e40p_snn_lif_neuron #(
            .DW(DW)
        ) u_neuron (
            .v_i         (mem_rdata_i[g*DW +: DW]),
            .cur_i       (cur_rdata_i[g*DW +: DW]),
            .thr_i       (thr_q),
            .leak_en_i   (leak_en_q),
            .leak_shift_i(shift_q),
            .reset_mode_i(mode_q),
            .v_o         (new_v[g*DW +: DW]),
            .spike_o     (spike_vec[g])
        );
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign spike_we_o  = we_q;
    // Read data is only valid in the write cycle, so the update is driven combinationally there.
    assign mem_wdata_o = we_q ? new_v : '0;
    assign spike_o     = we_q ? spike_vec : '0;

endmodule

// File: doc/cv32e40p_snn_lif_ctrl.md
Name: cv32e40p_snn_lif_ctrl

Overview:
Row-serial sequencer for the LIF neuron update over the membrane cache (ROWS x COLS signed 16-bit potentials).
- On start, walks every row: read membrane and input-current rows, apply leak shift, integrate, threshold, fire, reset, write back.
- Emits one spike vector per row.
- Sits between the SNN custom-instruction decode (start/config) and the membrane/current storage inside the cv32e40p SNN extension.

Parameters:
ROWS, 8, number of membrane rows (addressable entries)
COLS, 16, neurons per row
DW, 16, membrane/current data width (signed)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  one-cycle request to run a full update pass
abort_i  input  1  cancel the pass in progress
leak_en_i  input  1  apply leak; 0 = no leak
leak_shift_i  input  2  arithmetic right-shift amount 0..3
threshold_i  input  DW  signed firing threshold
reset_mode_i  input  1  0 = reset to zero, 1 = subtract threshold
busy_o  output  1  pass in progress
done_o  output  1  one-cycle pulse after the last row is written
mem_rd_en_o  output  1  row read strobe (membrane and current, same address)
mem_addr_o  output  $clog2(ROWS)  row address for read and write
mem_rdata_i  input  COLS*DW  membrane row; valid one cycle after mem_rd_en_o
cur_rdata_i  input  COLS*DW  input-current row; same timing as mem_rdata_i
mem_we_o  output  1  membrane row write strobe
mem_wdata_o  output  COLS*DW  updated membrane row
spike_we_o  output  1  spike row valid; same cycle as mem_we_o
spike_o  output  COLS  spike bits for row mem_addr_o

Behaviour:
Reset and start:
- Reset values: busy_o=0, done_o=0, mem_rd_en_o=0, mem_we_o=0, spike_we_o=0, mem_addr_o=0, mem_wdata_o=0, spike_o=0; FSM in IDLE.
- Config (leak_en, shift, threshold, reset_mode) is latched on the accepted start and held for the whole pass. Input changes mid-pass are ignored.

FSM:
- IDLE: start_i -> READ with row=0, busy_o=1. start_i while busy is ignored, with no queuing.
- READ: mem_rd_en_o=1, mem_addr_o=row -> WRITE.
- WRITE: data valid. Compute per neuron, drive mem_we_o=1 and spike_we_o=1 with the same mem_addr_o.
  - If row==ROWS-1 -> DONE.
  - Otherwise row+1 -> READ.
- DONE: done_o=1 for one cycle, busy_o=0 -> IDLE. start_i in DONE is ignored.

Timing:
- Two cycles per row. With ROWS=8, done_o is asserted in cycle 17 after the start cycle (start cycle = 0).

Per-neuron arithmetic (signed, DW bits):
- leaked = leak_en ? v >>> shift : v.
- sum = leaked + cur, computed at DW+1 bits, then narrowed to DW (see optional feature).
- spike = (sum >= threshold), signed compare. threshold<=0 is legal and fires on any sum >= threshold.
- new_v:
  - not spiked: sum
  - reset_mode=0: 0
  - reset_mode=1: sum - threshold at DW+1 bits, narrowed the same way as sum.

Abort and reset:
- abort_i: at any state other than IDLE, next state is IDLE. No done_o. A write asserted in the same cycle as abort still completes; later rows are not touched.
- Reset mid-pass: same as abort, plus all outputs return to reset values.
- Simultaneous abort_i and start_i in IDLE: start wins.

Optional Feature:
SNN_LIF_SATURATE_EN
- Defined: sum and subtract results clamp to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: results wrap (drop the MSB, two's complement truncation).

Decomposition:
- Package cv32e40p_snn_pkg: state enum lif_state_e (IDLE, READ, WRITE, DONE), SNN_MEM_ROWS=8, SNN_MEM_COLS=16, SNN_MEM_DW=16, and the signed neuron typedef.
- Sub-module cv32e40p_snn_lif_neuron: purely combinational, one neuron (leak, add, narrow, compare, reset). Instantiated COLS times via generate. The FSM stays in the top.

Test Plan:
- Single row: v=100, shift=1, leak_en=1, cur=30, thr=64, mode=0 -> sum 80, spike=1, wdata=0. Same with mode=1 -> wdata=16.
- No leak, no fire: v=-50, leak_en=0, cur=20, thr=64 -> wdata=-30, spike=0. Also v=-7, shift=3 -> leaked=-1 (arithmetic shift).
- Saturation: v=32767, leak_en=0, cur=100.
  - With SNN_LIF_SATURATE_EN: wdata=32767, and the neuron spikes if thr<=32767.
  - Without the macro: wdata=-32669.
- Full pass: start at cycle 0 -> 8 reads at cycles 1,3,...,15; writes at 2,4,...,16 with addresses 0..7; done_o only at cycle 17; busy_o high cycles 1-16.
- Abort: abort_i at cycle 6 -> rows 0-2 written, row 3 never written, no done_o, busy_o=0 from cycle 7. start_i at cycle 4 is ignored.
- Sync reset at cycle 9 -> all outputs 0 at cycle 10. A fresh start then restarts from row 0.
